load_store_unit: RTL and testbench

Pipeline-side initiator for the word-organised data memory: accepts one load or store per handshake from the execute stage and turns RISC-V func3 into word-aligned addresses, byte strobes, lane-replicated store data and sign- or zero-extended load results. It sits between the ALU/execute stage and the data memory port. It holds the pipeline through a grant/response handshake with a bounded timeout. It reports misaligned, illegal or timed-out accesses instead of touching memory.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/load_store_unit_align.sv | 84 ++++++++
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// response error codes, RISC-V func3 width codes and the legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } resp_err_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // An access is illegal when its kind is ambiguous or func3 names no
  // width that this kind of access supports (stores have no unsigned forms).
  function automatic logic lsu_is_illegal(input logic       is_load,
                                          input logic       is_store,
                                          input logic [2:0] func3);
    logic bad;
    if (is_load == is_store) begin
      bad = 1'b1;
    end else if (is_load) begin
      bad = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
    end else begin
      bad = (func3 > F3_W);
    end
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic. On the store side it replicates store data
// across byte lanes and builds the write strobes; on the load side it
// picks the addressed byte/half out of the raw word and extends it.
// The misalignment flag depends only on width and address, so it is
// valid for both kinds of access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load_i,
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  strb_o,
  output logic        misalign_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_s;
  logic [31:0] store_s;
  logic [3:0]  strb_s;

  assign half_s = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];

  // Select the byte lane addressed by the low address bits.
  always_comb begin
    byte_s = data_i[7:0];
    case (addr_lo_i)
      2'b00:   byte_s = data_i[7:0];
      2'b01:   byte_s = data_i[15:8];
      2'b10:   byte_s = data_i[23:16];
      2'b11:   byte_s = data_i[31:24];
      default: byte_s = data_i[7:0];
    endcase
  end

  // Sign- or zero-extend the selected lane according to func3.
  always_comb begin
    load_s = 32'h0000_0000;
    case (func3_i)
      F3_B:    load_s = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_s = {24'h00_0000, byte_s};
      F3_H:    load_s = {{16{half_s[15]}}, half_s};
      F3_HU:   load_s = {16'h0000, half_s};
      F3_W:    load_s = data_i;
      default: load_s = 32'h0000_0000;
    endcase
  end

  // Replicate store data over all lanes and enable only the written bytes.
  always_comb begin
    store_s = data_i;
    strb_s  = 4'b1111;
    case (func3_i[1:0])
      2'b00: begin
        store_s = {4{data_i[7:0]}};
        strb_s  = 4'b0001 << addr_lo_i;
      end
      2'b01: begin
        store_s = {2{data_i[15:0]}};
        strb_s  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_s = data_i;
        strb_s  = 4'b1111;
      end
    endcase
  end

  // Halfwords need an even address, words a word-aligned one.
  always_comb begin
    misalign_o = 1'b0;
    case (func3_i[1:0])
      2'b01:   misalign_o = addr_lo_i[0];
      2'b10:   misalign_o = (addr_lo_i != 2'b00);
      default: misalign_o = 1'b0;
    endcase
  end

  assign data_o = is_load_i ? load_s : store_s;
  assign strb_o = is_load_i ? 4'b0000 : strb_s;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access per handshake, rejects illegal or
// misaligned ones without touching memory, otherwise runs a
// request/grant/rvalid exchange bounded by TIMEOUT cycles and returns a
// single registered response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [1:0]  resp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [16:0] TIMEOUT_C = 17'(TIMEOUT);

  lsu_state_e  state_q;
  resp_err_e   resp_err_q;
  logic        is_load_q;
  logic [2:0]  func3_q;
  logic [1:0]  addr_lo_q;
  logic [15:0] cnt_q;
  logic [16:0] cnt_d;
  logic        timeout_hit_s;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;

  logic        illegal_s;
  logic        misalign_s;
  logic [31:0] st_data_s;
  logic [3:0]  st_strb_s;
  logic [31:0] ld_data_s;
  logic [3:0]  ld_strb_unused_s;
  logic        ld_misalign_unused_s;

  // Request-side lanes and alignment check, evaluated on the live request.
  lsu_align u_store_align (
    .is_load_i  (is_load_i),
    .func3_i    (func3_i),
    .addr_lo_i  (addr_i[1:0]),
    .data_i     (wdata_i),
    .data_o     (st_data_s),
    .strb_o     (st_strb_s),
    .misalign_o (misalign_s)
  );

  // Response-side extraction of the returned word using the latched request.
  lsu_align u_load_align (
    .is_load_i  (1'b1),
    .func3_i    (func3_q),
    .addr_lo_i  (addr_lo_q),
    .data_i     (mem_rdata_i),
    .data_o     (ld_data_s),
    .strb_o     (ld_strb_unused_s),
    .misalign_o (ld_misalign_unused_s)
  );

  assign illegal_s     = lsu_is_illegal(is_load_i, is_store_i, func3_i);
  assign cnt_d         = {1'b0, cnt_q} + 17'd1;
  assign timeout_hit_s = (cnt_d == TIMEOUT_C);

  // Control FSM; all memory-side and response outputs are registered here.
  // A completing grant/rvalid wins over a timeout in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      resp_err_q   <= ERR_NONE;
      is_load_q    <= 1'b0;
      func3_q      <= 3'b000;
      addr_lo_q    <= 2'b00;
      cnt_q        <= 16'h0000;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      mem_wstrb_q  <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            is_load_q <= is_load_i;
            func3_q   <= func3_i;
            addr_lo_q <= addr_i[1:0];
            cnt_q     <= 16'h0000;
            if (illegal_s) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= ERR_ILLEGAL;
              resp_rdata_q <= 32'h0000_0000;
            end else if (misalign_s) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= ERR_MISALIGN;
              resp_rdata_q <= 32'h0000_0000;
            end else begin
              state_q     <= ST_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store_i;
              mem_addr_q  <= {addr_i[31:2], 2'b00};
              mem_wdata_q <= st_data_s;
              mem_wstrb_q <= st_strb_s;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            if (!is_load_q) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= ERR_NONE;
              resp_rdata_q <= 32'h0000_0000;
            end else if (mem_rvalid_i) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= ERR_NONE;
              resp_rdata_q <= ld_data_s;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= cnt_d[15:0];
            end
          end else if (timeout_hit_s) begin
            mem_req_q    <= 1'b0;
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ERR_TIMEOUT;
            resp_rdata_q <= 32'h0000_0000;
          end else begin
            cnt_q <= cnt_d[15:0];
          end
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ERR_NONE;
            resp_rdata_q <= ld_data_s;
          end else if (timeout_hit_s) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ERR_TIMEOUT;
            resp_rdata_q <= 32'h0000_0000;
          end else begin
            cnt_q <= cnt_d[15:0];
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_wstrb_o  = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit (TIMEOUT = 4). Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_load_store_unit;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  func3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic [1:0]  resp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  // results of the last run_access
  int          r_lat;
  int          r_rc;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic        r_we;
  logic [1:0]  r_err;
  logic [31:0] r_rdata;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .is_load_i    (is_load_i),
    .is_store_i   (is_store_i),
    .func3_i      (func3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one access at the current falling edge, model grant/rvalid
  // delays, and record latency and first-request outputs.
  task automatic run_access(input string tag, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int gnt_dly,
                            input int rv_dly, input logic [31:0] rd);
    bit done;
    done = 1'b0;
    r_lat = -1; r_rc = 0; r_addr = 32'h0; r_wdata = 32'h0; r_strb = 4'h0;
    r_we = 1'b0; r_err = 2'b00; r_rdata = 32'h0;
    check_eq({tag, ":ready"}, {31'h0, req_ready_o}, 32'h1);
    req_valid_i = 1'b1; is_load_i = ld; is_store_i = st;
    func3_i = f3; addr_i = a; wdata_i = wd;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      if (k == 1) check_eq({tag, ":busy"}, {31'h0, req_ready_o}, 32'h0);
      if (mem_req_o) begin
        if (r_rc == 0) begin
          r_addr = mem_addr_o; r_wdata = mem_wdata_o; r_strb = mem_wstrb_o; r_we = mem_we_o;
        end
        r_rc++;
      end
      if (resp_valid_o) begin
        done = 1'b1; r_lat = k; r_err = resp_err_o; r_rdata = resp_rdata_o;
      end
      mem_gnt_i    = !done && (k == 1 + gnt_dly);
      mem_rvalid_i = !done && ld && (k == 1 + gnt_dly + rv_dly);
      mem_rdata_i  = mem_rvalid_i ? rd : ~rd;
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    check_eq({tag, ":done"}, {31'h0, done}, 32'h1);
    @(negedge clk);
    check_eq({tag, ":pulse"}, {31'h0, resp_valid_o}, 32'h0);
  endtask

  // Common response checks for the last access.
  task automatic chk_resp(input string tag, input int lat, input int rc,
                          input logic [1:0] err, input logic [31:0] rdata);
    check_eq({tag, ":lat"}, r_lat, lat);
    check_eq({tag, ":reqcyc"}, r_rc, rc);
    check_eq({tag, ":err"}, {30'h0, r_err}, {30'h0, err});
    check_eq({tag, ":rdata"}, r_rdata, rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    func3_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    // reset values
    @(negedge clk);
    check_eq("rst:ready", {31'h0, req_ready_o}, 32'h1);
    check_eq("rst:mem_req", {31'h0, mem_req_o}, 32'h0);
    check_eq("rst:mem_we", {31'h0, mem_we_o}, 32'h0);
    check_eq("rst:mem_addr", mem_addr_o, 32'h0);
    check_eq("rst:mem_wdata", mem_wdata_o, 32'h0);
    check_eq("rst:mem_wstrb", {28'h0, mem_wstrb_o}, 32'h0);
    check_eq("rst:resp_valid", {31'h0, resp_valid_o}, 32'h0);
    check_eq("rst:resp_rdata", resp_rdata_o, 32'h0);
    check_eq("rst:resp_err", {30'h0, resp_err_o}, 32'h0);
    rst_i = 1'b0;
    @(negedge clk);

    // SB, immediate grant
    run_access("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0);
    chk_resp("sb", 2, 1, 2'b00, 32'h0);
    check_eq("sb:addr", r_addr, 32'h0000_0100);
    check_eq("sb:strb", {28'h0, r_strb}, 32'h8);
    check_eq("sb:wdata", r_wdata, 32'hA5A5_A5A5);
    check_eq("sb:we", {31'h0, r_we}, 32'h1);

    // LB / LBU with rvalid three cycles after grant
    run_access("lb", 1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 0, 3, 32'h1234_F678);
    chk_resp("lb", 5, 1, 2'b00, 32'hFFFF_FFF6);
    check_eq("lb:we", {31'h0, r_we}, 32'h0);
    check_eq("lb:strb", {28'h0, r_strb}, 32'h0);
    check_eq("lb:addr", r_addr, 32'h0000_0100);
    run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 0, 3, 32'h1234_F678);
    chk_resp("lbu", 5, 1, 2'b00, 32'h0000_00F6);

    // LH / LHU upper half, zero-wait
    run_access("lh", 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 0, 32'h8001_7FFF);
    chk_resp("lh", 2, 1, 2'b00, 32'hFFFF_8001);
    run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 0, 32'h8001_7FFF);
    chk_resp("lhu", 2, 1, 2'b00, 32'h0000_8001);

    // SW with one grant-wait cycle
    run_access("sw", 1'b0, 1'b1, 3'b010, 32'h0000_010C, 32'hDEAD_BEEF, 1, 0, 32'h0);
    chk_resp("sw", 3, 2, 2'b00, 32'h0);
    check_eq("sw:strb", {28'h0, r_strb}, 32'hF);
    check_eq("sw:wdata", r_wdata, 32'hDEAD_BEEF);
    check_eq("sw:addr", r_addr, 32'h0000_010C);

    // error paths: no memory request, response one cycle after accept
    run_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 0, 32'h1111_1111);
    chk_resp("lw_mis", 1, 0, 2'b01, 32'h0);
    run_access("lhu_mis", 1'b1, 1'b0, 3'b101, 32'h0000_0101, 32'h0, 0, 0, 32'h1111_1111);
    chk_resp("lhu_mis", 1, 0, 2'b01, 32'h0);
    run_access("st_f3_011", 1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0, 0, 0, 32'h0);
    chk_resp("st_f3_011", 1, 0, 2'b10, 32'h0);
    run_access("ld_prio", 1'b1, 1'b0, 3'b110, 32'h0000_0101, 32'h0, 0, 0, 32'h0);
    chk_resp("ld_prio", 1, 0, 2'b10, 32'h0);
    run_access("both", 1'b1, 1'b1, 3'b000, 32'h0000_0100, 32'h0, 0, 0, 32'h0);
    chk_resp("both", 1, 0, 2'b10, 32'h0);

    // timeout: grant never arrives
    run_access("tmo", 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1000, 0, 32'h0);
    chk_resp("tmo", 5, 4, 2'b11, 32'h0);
    begin
      int spurious;
      spurious = 0;
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (resp_valid_o || mem_req_o || !req_ready_o) spurious++;
      end
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      check_eq("late_rvalid:ignored", spurious, 0);
    end
    run_access("after_tmo", 1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 0, 0, 32'hCAFE_0042);
    chk_resp("after_tmo", 2, 1, 2'b00, 32'hCAFE_0042);

    // back-to-back SH with req_valid held and 2-cycle grant delay
    begin
      int accepts, resps, req_hi, ready_bad, ready_lo;
      logic [3:0]  strb0, strb1;
      logic [31:0] wd0;
      accepts = 0; resps = 0; req_hi = 0; ready_bad = 0; ready_lo = 0;
      strb0 = 4'h0; strb1 = 4'h0; wd0 = 32'h0;
      is_load_i = 1'b0; is_store_i = 1'b1; func3_i = 3'b001;
      addr_i = 32'h0000_0200; wdata_i = 32'h0000_5A3C; req_valid_i = 1'b1;
      if (req_ready_o) accepts = 1;
      for (int k = 0; k < 40 && resps < 2; k++) begin
        @(negedge clk);
        if (resp_valid_o) resps++;
        if (!req_ready_o) ready_lo++;
        if (req_ready_o && (mem_req_o || resp_valid_o)) ready_bad++;
        if (mem_req_o) begin
          if (req_hi == 0) begin
            if (accepts == 1) begin strb0 = mem_wstrb_o; wd0 = mem_wdata_o; end
            else strb1 = mem_wstrb_o;
          end
          req_hi++;
        end else begin
          req_hi = 0;
        end
        mem_gnt_i = mem_req_o && (req_hi == 3);
        if (accepts == 1) addr_i = 32'h0000_0202;
        if (accepts == 2) req_valid_i = 1'b0;
        if (req_valid_i && req_ready_o) accepts++;
      end
      mem_gnt_i = 1'b0; req_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (resp_valid_o) resps++;
      end
      check_eq("b2b:accepts", accepts, 2);
      check_eq("b2b:resps", resps, 2);
      check_eq("b2b:strb0", {28'h0, strb0}, 32'h3);
      check_eq("b2b:strb1", {28'h0, strb1}, 32'hC);
      check_eq("b2b:wdata0", wd0, 32'h5A3C_5A3C);
      check_eq("b2b:ready_lo", ready_lo, 8);
      check_eq("b2b:ready_bad", ready_bad, 0);
    end

    // reset while waiting for read data
    begin
      int spurious;
      spurious = 0;
      is_load_i = 1'b1; is_store_i = 1'b0; func3_i = 3'b000;
      addr_i = 32'h0000_0100; req_valid_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0; mem_gnt_i = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
      check_eq("rstw:in_wait", {31'h0, req_ready_o}, 32'h0);
      #2 rst_i = 1'b1;
      #1;
      check_eq("rstw:ready_async", {31'h0, req_ready_o}, 32'h1);
      check_eq("rstw:mem_req", {31'h0, mem_req_o}, 32'h0);
      check_eq("rstw:resp_valid", {31'h0, resp_valid_o}, 32'h0);
      @(negedge clk);
      rst_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        if (resp_valid_o || !req_ready_o) spurious++;
      end
      check_eq("rstw:no_resp", spurious, 0);
    end
    run_access("post_rst", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 0, 32'h9A00_0000);
    chk_resp("post_rst", 2, 1, 2'b00, 32'h0000_009A);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
